div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
Shares one sequential restoring divider between NREQ requesters. Each requester supplies a DW-bit dividend and a VW-bit divisor. A round-robin arbiter grants one requester at a time and sequences the divide core one quotient bit per cycle. The result returns on a single valid/ready response channel tagged with the requester id. The block sits between client state machines and the fixed-point division datapath, replacing per-client dividers.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, dividend and quotient width
VW, 4, divisor and remainder width (VW < DW)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_dividend  in  NREQ*DW  flattened dividends, requester i at [i*DW +: DW]
req_divisor  in  NREQ*VW  flattened divisors, requester i at [i*VW +: VW]
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  $clog2(NREQ)  index of the served requester
rsp_quotient  out  DW  quotient
rsp_remainder  out  VW  remainder
rsp_div_by_zero  out  1  divisor was zero
busy  out  1  high in RUN or DONE

Behaviour:
- Reset is asynchronous, active-low; one clock domain. In reset, every output is 0, the FSM is in IDLE and the RR pointer is 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant goes to the first requester with req_valid set, searching from ptr upward and wrapping modulo NREQ.
  - req_ready[g] is asserted combinationally in the same cycle. The valid->ready path is combinational; ready never depends on ready.
  - On handshake: capture the operands and g, set ptr = (g+1) mod NREQ.
  - Next state is DONE if the divisor is 0, else RUN.
- RUN: lasts exactly DW cycles, one restoring step per cycle, MSB first.
  - Partial remainder R is VW+1 bits, cleared at start.
  - Each step: T = {R[VW-1:0], next dividend bit}. If T >= divisor then R = T - divisor and the q bit is 1; otherwise R = T and the q bit is 0.
  - After DW steps, register the quotient and R[VW-1:0] into the rsp_* outputs and go to DONE.
- DONE:
  - rsp_valid = 1; all rsp_* outputs are registered and held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE next cycle and drop rsp_valid.
  - No request is accepted in the same cycle, so there is a mandatory 1-cycle bubble.
- Latency: handshake at cycle T gives rsp_valid at T+DW+1 for a nonzero divisor, and at T+1 for a zero divisor. Minimum issue interval is DW+2 cycles.
- Divide by zero: RUN is skipped. Output rsp_quotient = all ones, rsp_remainder = 0, rsp_div_by_zero = 1.
- req_ready is all 0 outside IDLE. Requests held while busy wait; no queuing beyond the captured operand registers.
- Fairness: a requester that holds req_valid is served within NREQ grants.
- Reset mid-operation: the in-flight request is discarded and no response is produced. Requesters must reissue.
- req_valid dropping without ready is legal; there is no request-stability requirement before acceptance.

Decomposition:
- Shared package div_pkg holds:
  - default DW and VW constants;
  - FSM state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the divide-by-zero quotient constant (all ones).
- One sub-module, div_restoring_core. Ports: clk, rst_n, start, dividend, divisor, done, quotient, remainder.
  - It holds the shift/subtract step and the DW-cycle step counter.
  - The top holds the arbiter, RR pointer, FSM and response registers.

Test Plan:
- Single request, req 0 with 13/5 at cycle T: req_ready[0]=1 at T; rsp_valid at T+9 with quotient 2, remainder 3, rsp_id 0, rsp_div_by_zero 0.
- Divide by zero, req 1 with 200/0 alone: rsp_valid at T+1 with quotient 0xFF, remainder 0, div_by_zero 1, id 1.
- Fairness: all four req_valid held high with operands i*16+7 / i+1, rsp_ready tied high:
  - grant order 0,1,2,3,0;
  - responses 7/1 = 7 r0, 23/2 = 11 r1, 39/3 = 13 r0, 55/4 = 13 r3.
- Backpressure: rsp_ready low for 5 cycles in DONE: rsp_* stable, req_ready all 0, busy 1. When rsp_ready rises, rsp_valid falls the next cycle and IDLE accepts the cycle after.
- Boundary operands:
  - 255/1 gives 255 r0;
  - 255/15 gives 17 r0;
  - 254/15 gives 16 r14;
  - 0/7 gives 0 r0;
  - 3/15 gives 0 r3.
- Reset mid-RUN: assert rst_n=0 three cycles after acceptance. All outputs go to 0 immediately and ptr goes to 0. After release, no stale rsp_valid appears, and a new request to req 0 is served first.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared default widths, FSM state encoding and divide-by-zero quotient for the shared divider
package div_pkg;
  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [63:0] DBZ_Q = '1;
endpackage

// File: rtl/div_restoring_core.sv
// div_restoring_core: DW-step restoring divider; start loads dividend/divisor, done marks the last step, quotient/remainder are valid with done
module div_restoring_core import div_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  logic [DW-1:0] a, a_nx;
  logic [VW:0] r, r_nx, t;
  logic [VW-1:0] d;
  logic [CW-1:0] cnt;
  logic run, ge;
  assign t = {r[VW-1:0], a[DW-1]};
  assign ge = t >= {1'b0, d};
  assign r_nx = ge ? t - {1'b0, d} : t;
  assign a_nx = {a[DW-2:0], ge};
  assign done = run && cnt == LAST;
  assign quotient = a_nx;
  assign remainder = r_nx[VW-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      r <= '0;
      d <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      a <= dividend;
      r <= '0;
      d <= divisor;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      a <= a_nx;
      r <= r_nx;
      cnt <= cnt + 1'b1;
      run <= !done;
    end
endmodule

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin shares one restoring divider among NREQ requesters; req_* valid/ready in, rsp_* valid/ready out tagged with rsp_id, busy in RUN/DONE
module div_share_arbiter import div_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DW-1:0]      req_dividend,
  input  logic [NREQ*VW-1:0]      req_divisor,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [DW-1:0]           rsp_quotient,
  output logic [VW-1:0]           rsp_remainder,
  output logic                    rsp_div_by_zero,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  state_t st, st_nx;
  logic [IW-1:0] ptr, gnt, idx;
  logic gnt_ok, hs, zero, core_done;
  logic [DW-1:0] sel_a, core_q;
  logic [VW-1:0] sel_b, core_r;
  always_comb begin
    gnt = '0;
    gnt_ok = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        gnt = idx;
        gnt_ok = 1'b1;
      end
    end
  end
  assign sel_a = req_dividend[gnt*DW +: DW];
  assign sel_b = req_divisor[gnt*VW +: VW];
  assign zero = sel_b == '0;
  assign hs = rst_n && st == IDLE && gnt_ok;
  assign req_ready = hs ? NREQ'(1) << gnt : '0;
  assign rsp_valid = st == DONE;
  assign busy = st != IDLE;
  always_comb
    st_nx = st == IDLE ? (hs ? (zero ? DONE : RUN) : IDLE)
          : st == RUN  ? (core_done ? DONE : RUN)
          : (rsp_ready ? IDLE : DONE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      ptr <= '0;
      rsp_id <= '0;
      rsp_quotient <= '0;
      rsp_remainder <= '0;
      rsp_div_by_zero <= 1'b0;
    end else begin
      st <= st_nx;
      if (hs) begin
        ptr <= gnt == IW'(NREQ - 1) ? '0 : gnt + 1'b1;
        rsp_id <= gnt;
      end
      if (hs && zero) begin
        rsp_quotient <= DBZ_Q[DW-1:0];
        rsp_remainder <= '0;
        rsp_div_by_zero <= 1'b1;
      end else if (core_done) begin
        rsp_quotient <= core_q;
        rsp_remainder <= core_r;
        rsp_div_by_zero <= 1'b0;
      end
    end
  div_restoring_core #(.DW(DW), .VW(VW)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .start(hs && !zero),
    .dividend(sel_a),
    .divisor(sel_b),
    .done(core_done),
    .quotient(core_q),
    .remainder(core_r)
  );
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: randomized and directed checks of the shared divider against a transaction-level model
module tb_div_share_arbiter;
  localparam int N = 4, DW = 8, VW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready;
  logic [N*DW-1:0] req_dividend;
  logic [N*VW-1:0] req_divisor;
  logic rsp_valid, rsp_ready, rsp_div_by_zero, busy;
  logic [1:0] rsp_id;
  logic [DW-1:0] rsp_quotient;
  logic [VW-1:0] rsp_remainder;
  div_share_arbiter #(.NREQ(N), .DW(DW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_div_by_zero(rsp_div_by_zero), .busy(busy)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  logic [3:0] va;
  logic [7:0] da [4];
  logic [3:0] dv [4];
  logic rdy;
  bit pend;
  int due, mptr, eid, eq, er, edbz;
  int gq[$], rq[$], rm[$];
  int lq, lr, lid, ldbz;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    int eg;
    bit ev;
    req_valid = va;
    req_dividend = {da[3], da[2], da[1], da[0]};
    req_divisor = {dv[3], dv[2], dv[1], dv[0]};
    rsp_ready = rdy;
    #2;
    eg = -1;
    if (!pend)
      for (int k = 0; k < N; k++)
        if (eg < 0 && va[(mptr + k) % N]) eg = (mptr + k) % N;
    chk("req_ready", req_ready, eg < 0 ? 4'd0 : 4'(1 << eg));
    for (int k = 0; k < N; k++) if (req_ready[k]) gq.push_back(k);
    chk("busy", busy, pend);
    ev = pend && cyc >= due;
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("rsp_id", rsp_id, eid);
      chk("rsp_quotient", rsp_quotient, eq);
      chk("rsp_remainder", rsp_remainder, er);
      chk("rsp_div_by_zero", rsp_div_by_zero, edbz);
      if (rdy) begin
        lq = rsp_quotient; lr = rsp_remainder; lid = rsp_id; ldbz = rsp_div_by_zero;
        rq.push_back(lq); rm.push_back(lr);
        pend = 0;
      end
    end else if (eg >= 0) begin
      pend = 1;
      eid = eg;
      edbz = dv[eg] == 0;
      eq = edbz ? 255 : int'(da[eg]) / int'(dv[eg]);
      er = edbz ? 0 : int'(da[eg]) % int'(dv[eg]);
      due = cyc + (edbz ? 1 : DW + 1);
      mptr = (eg + 1) % N;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic drain();
    va = '0;
    rdy = 1'b1;
    for (int n = 0; n < 40 && pend; n++) step();
    chk("drain", pend, 0);
  endtask
  task automatic serve(int id, int a, int b);
    va = '0;
    va[id] = 1'b1;
    da[id] = 8'(a);
    dv[id] = 4'(b);
    rdy = 1'b1;
    for (int n = 0; n < 6 && !pend; n++) step();
    chk("serve_accept", pend, 1);
    drain();
  endtask
  int ord[5] = '{0, 1, 2, 3, 0};
  int fq[4] = '{7, 11, 13, 13};
  int fr[4] = '{0, 1, 0, 3};
  int ba[5] = '{255, 255, 254, 0, 3};
  int bb[5] = '{1, 15, 15, 7, 15};
  int bq[5] = '{255, 17, 16, 0, 0};
  int br[5] = '{0, 0, 14, 0, 3};
  initial begin
    va = '0; rdy = 1'b1; pend = 0; mptr = 0;
    for (int i = 0; i < N; i++) begin da[i] = '0; dv[i] = '0; end
    req_valid = 4'hF; req_dividend = '0; req_divisor = '0; rsp_ready = 1'b1;
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quotient", rsp_quotient, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gq.delete(); rq.delete(); rm.delete();
    for (int i = 0; i < N; i++) begin da[i] = 8'(i * 16 + 7); dv[i] = 4'(i + 1); end
    va = 4'hF;
    for (int n = 0; n < 80 && gq.size() < 5; n++) step();
    drain();
    chk("fair_cnt", gq.size(), 5);
    for (int i = 0; i < 5; i++) chk("fair_order", i < gq.size() ? gq[i] : -1, ord[i]);
    for (int i = 0; i < 4; i++) begin
      chk("fair_q", i < rq.size() ? rq[i] : -1, fq[i]);
      chk("fair_r", i < rm.size() ? rm[i] : -1, fr[i]);
    end
    serve(0, 13, 5);
    chk("t13_q", lq, 2); chk("t13_r", lr, 3); chk("t13_id", lid, 0);
    serve(1, 200, 0);
    chk("dbz_q", lq, 255); chk("dbz_r", lr, 0); chk("dbz_flag", ldbz, 1); chk("dbz_id", lid, 1);
    for (int i = 0; i < 5; i++) begin
      serve(0, ba[i], bb[i]);
      chk("bnd_q", lq, bq[i]);
      chk("bnd_r", lr, br[i]);
    end
    va = 4'b0100; da[2] = 8'd100; dv[2] = 4'd7; rdy = 1'b0;
    for (int n = 0; n < 6 && !pend; n++) step();
    va = 4'hF;
    for (int n = 0; n < 20 && !(pend && cyc >= due); n++) step();
    repeat (5) step();
    rdy = 1'b1; va = '0;
    step();
    va = 4'b0001;
    step();
    drain();
    for (int n = 0; n < 600; n++) begin
      va = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        da[i] = 8'($urandom_range(0, 255));
        dv[i] = 4'($urandom_range(0, 15));
      end
      rdy = ($urandom % 4) != 0;
      step();
    end
    drain();
    va = 4'b0100; da[2] = 8'd77; dv[2] = 4'd3; rdy = 1'b1;
    for (int n = 0; n < 6 && !pend; n++) step();
    va = 4'b1001;
    repeat (3) step();
    req_valid = va;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_q", rsp_quotient, 0);
    chk("mid_rst_r", rsp_remainder, 0);
    chk("mid_rst_dbz", rsp_div_by_zero, 0);
    pend = 0; mptr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    gq.delete();
    for (int n = 0; n < 3; n++) step();
    chk("post_rst_first", gq.size() > 0 ? gq[0] : -1, 0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
